mips_seq_ctrl: RTL and testbench

Multicycle sequencer for the mips32 core datapath. It steps the FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequence and drives the PC, IR, register-file and data-memory control strobes, including wait states for memories that are not single-cycle. It sits between the slow-tick generator and the datapath, and exposes its state code for the HEX1 display.

---
 rtl/mips_seq_pkg.sv | 51 +++++
 rtl/mips_seq_ctrl_if.sv | 47 ++++
 rtl/mips_seq_decode.sv | 37 +++
 rtl/mips_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_mips_seq_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_seq_pkg.sv
// Shared encodings for the mips32 multicycle sequencer: state codes, instruction
// classes, opcode/funct constants and the ALU / next-PC select encodings.
package mips_seq_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_TRAP      = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      IC_NOP, IC_ALU_R, IC_ADDI, IC_LW, IC_SW, IC_BEQ, IC_J, IC_ILLEGAL
   } iclass_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_t;

   typedef enum logic [1:0] {
      PC_INC    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2
   } pc_src_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_NOP = 6'b000000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // Classes whose last state is EXECUTE; they retire on leaving it.
   function automatic logic retires_in_execute(input iclass_t c);
      return (c == IC_NOP) || (c == IC_BEQ) || (c == IC_J);
   endfunction

endpackage

// File: rtl/mips_seq_ctrl_if.sv
// Sequencer <-> datapath bundle. The retired count exists only when
// MIPS_SEQ_RETIRE_CNT_EN is defined.
interface mips_seq_ctrl_if
`ifdef MIPS_SEQ_RETIRE_CNT_EN
   #(parameter int RETIRE_W = 16)
`endif
   ;
   logic       tick;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       alu_zero;
   logic       mem_ready;
   logic [2:0] state;
   logic       pc_we;
   logic       ir_we;
   logic       rf_we;
   logic       mem_we;
   logic       mem_re;
   logic [1:0] pc_src;
   logic [2:0] alu_op;
   logic       alu_src_imm;
   logic       rf_dst_rt;
   logic       rf_wdata_mem;
   logic       trap;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
   logic [RETIRE_W-1:0] retired;
`endif

   modport master (
      output tick, opcode, funct, alu_zero, mem_ready,
      input  state, pc_we, ir_we, rf_we, mem_we, mem_re, pc_src, alu_op,
             alu_src_imm, rf_dst_rt, rf_wdata_mem, trap
`ifdef MIPS_SEQ_RETIRE_CNT_EN
      , input retired
`endif
   );

   modport slave (
      input  tick, opcode, funct, alu_zero, mem_ready,
      output state, pc_we, ir_we, rf_we, mem_we, mem_re, pc_src, alu_op,
             alu_src_imm, rf_dst_rt, rf_wdata_mem, trap
`ifdef MIPS_SEQ_RETIRE_CNT_EN
      , output retired
`endif
   );

endinterface

// File: rtl/mips_seq_decode.sv
// Combinational instruction classifier: opcode/funct -> iclass, plus the ALU
// operation for register-register instructions.
module mips_seq_decode
   import mips_seq_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    iclass,
   output alu_op_t    alu_op
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      iclass = IC_ILLEGAL;
      alu_op = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_NOP: iclass = IC_NOP;
               FN_ADD: begin iclass = IC_ALU_R; alu_op = ALU_ADD; end
               FN_SUB: begin iclass = IC_ALU_R; alu_op = ALU_SUB; end
               FN_AND: begin iclass = IC_ALU_R; alu_op = ALU_AND; end
               FN_OR:  begin iclass = IC_ALU_R; alu_op = ALU_OR;  end
               FN_SLT: begin iclass = IC_ALU_R; alu_op = ALU_SLT; end
               default: ;
            endcase
         end
         OP_ADDI: iclass = IC_ADDI;
         OP_LW:   iclass = IC_LW;
         OP_SW:   iclass = IC_SW;
         OP_BEQ:  iclass = IC_BEQ;
         OP_J:    iclass = IC_J;
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the mips32 core.
// Optional retired-instruction counter: MIPS_SEQ_RETIRE_CNT_EN.
module mips_seq_ctrl
   import mips_seq_pkg::*;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
   #(parameter int RETIRE_W = 16)
`endif
(
   input logic            CLOCK_50,
   input logic            KEY0,
   mips_seq_ctrl_if.slave bus
);

   state_t  state_q;
   iclass_t iclass_q;
   alu_op_t alu_r_op_q;
   logic    trap_q;
   iclass_t dec_iclass;
   alu_op_t dec_alu_op;
   logic    advance;

   mips_seq_decode u_decode (
      .opcode (bus.opcode),
      .funct  (bus.funct),
      .iclass (dec_iclass),
      .alu_op (dec_alu_op)
   );

   // FETCH and MEMORY wait for the memory; the other live states step on every tick.
   always_comb begin
      advance = 1'b0;
      case (state_q)
         ST_FETCH, ST_MEMORY:                  advance = bus.tick && bus.mem_ready;
         ST_DECODE, ST_EXECUTE, ST_WRITEBACK:  advance = bus.tick;
         default:                              advance = 1'b0;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         // NOTE: non-blocking assignments keep every register updating off pre-edge values.
         state_q    <= ST_FETCH;
         iclass_q   <= IC_NOP;
         alu_r_op_q <= ALU_ADD;
         trap_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH:
               if (advance) state_q <= ST_DECODE;
            ST_DECODE:
               if (advance) begin
                  iclass_q   <= dec_iclass;
                  alu_r_op_q <= dec_alu_op;
                  if (dec_iclass == IC_ILLEGAL) begin
                     state_q <= ST_TRAP;
                     trap_q  <= 1'b1;
                  end else begin
                     state_q <= ST_EXECUTE;
                  end
               end
            ST_EXECUTE:
               if (advance) begin
                  case (iclass_q)
                     IC_ALU_R, IC_ADDI: state_q <= ST_WRITEBACK;
                     IC_LW, IC_SW:      state_q <= ST_MEMORY;
                     default:           state_q <= ST_FETCH;
                  endcase
               end
            ST_MEMORY:
               if (advance) state_q <= (iclass_q == IC_LW) ? ST_WRITEBACK : ST_FETCH;
            ST_WRITEBACK:
               if (advance) state_q <= ST_FETCH;
            ST_TRAP:
               state_q <= ST_TRAP;
            default:
               state_q <= ST_FETCH;
         endcase
      end
   end

   // Strobes pulse only in the advancing cycle; the rest are levels of state/iclass.
   always_comb begin
      bus.pc_we        = 1'b0;
      bus.ir_we        = 1'b0;
      bus.rf_we        = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_re       = 1'b0;
      bus.pc_src       = PC_INC;
      bus.alu_op       = ALU_ADD;
      bus.alu_src_imm  = 1'b0;
      bus.rf_dst_rt    = 1'b0;
      bus.rf_wdata_mem = 1'b0;
      case (state_q)
         ST_FETCH: begin
            bus.mem_re = 1'b1;
            bus.ir_we  = advance;
            bus.pc_we  = advance;
         end
         ST_EXECUTE: begin
            case (iclass_q)
               IC_ALU_R: bus.alu_op = alu_r_op_q;
               IC_ADDI, IC_LW, IC_SW: begin
                  bus.alu_op      = ALU_ADD;
                  bus.alu_src_imm = 1'b1;
               end
               IC_BEQ: begin
                  bus.alu_op = ALU_SUB;
                  bus.pc_src = PC_BRANCH;
                  bus.pc_we  = advance && bus.alu_zero;
               end
               IC_J: begin
                  bus.pc_src = PC_JUMP;
                  bus.pc_we  = advance;
               end
               default: ;
            endcase
         end
         ST_MEMORY: begin
            bus.mem_re = (iclass_q == IC_LW);
            bus.mem_we = (iclass_q == IC_SW);
         end
         ST_WRITEBACK: begin
            bus.rf_we        = advance;
            bus.rf_dst_rt    = (iclass_q == IC_ADDI) || (iclass_q == IC_LW);
            bus.rf_wdata_mem = (iclass_q == IC_LW);
         end
         default: ;
      endcase
   end

   assign bus.state = state_q;
   assign bus.trap  = trap_q;

`ifdef MIPS_SEQ_RETIRE_CNT_EN
   logic                retire;
   logic [RETIRE_W-1:0] retired_q;

   // A retirement is any advancing transition back into FETCH.
   always_comb begin
      retire = 1'b0;
      if (advance) begin
         case (state_q)
            ST_EXECUTE:   retire = retires_in_execute(iclass_q);
            ST_MEMORY:    retire = (iclass_q == IC_SW);
            ST_WRITEBACK: retire = 1'b1;
            default:      retire = 1'b0;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0)       retired_q <= '0;
      else if (retire) retired_q <= retired_q + 1'b1;
   end

   assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Scoreboard bench for mips_seq_ctrl: per-cycle expected outputs are queued with
// the stimulus and compared when the cycle is sampled, just before the rising edge.
module tb_mips_seq_ctrl;

   localparam int TB_RW = 4;

   typedef struct packed {
      logic       key0;
      logic       tick;
      logic       ready;
      logic       zero;
   } stim_t;

   typedef struct packed {
      logic [2:0] state;
      logic       pc_we;
      logic       ir_we;
      logic       rf_we;
      logic       mem_we;
      logic       mem_re;
      logic [1:0] pc_src;
      logic [2:0] alu_op;
      logic       alu_src_imm;
      logic       rf_dst_rt;
      logic       rf_wdata_mem;
      logic       trap;
   } obs_t;

   logic clk = 1'b0;
   logic KEY0;
   int   n_pass  = 0;
   int   n_total = 0;
   logic [TB_RW-1:0] exp_ret = '0;

   stim_t stim_q[$];
   obs_t  exp_q[$];

`ifdef MIPS_SEQ_RETIRE_CNT_EN
   mips_seq_ctrl_if #(.RETIRE_W(TB_RW)) bus ();
   mips_seq_ctrl #(.RETIRE_W(TB_RW)) dut (.CLOCK_50(clk), .KEY0(KEY0), .bus(bus));
`else
   mips_seq_ctrl_if bus ();
   mips_seq_ctrl dut (.CLOCK_50(clk), .KEY0(KEY0), .bus(bus));
`endif

   always #5 clk = ~clk;

   function automatic obs_t ex(input logic [2:0] st);
      obs_t o;
      o       = '0;
      o.state = st;
      return o;
   endfunction

   function automatic obs_t fe(input logic adv);
      obs_t o;
      o        = ex(3'd0);
      o.mem_re = 1'b1;
      o.ir_we  = adv;
      o.pc_we  = adv;
      return o;
   endfunction

   task automatic sb_push(input logic k, input logic t, input logic r, input logic z,
                          input obs_t e);
      stim_t s;
      s = '{key0: k, tick: t, ready: r, zero: z};
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic load(input logic [5:0] op, input logic [5:0] fn);
      bus.opcode = op;
      bus.funct  = fn;
   endtask

   task automatic drive_sample(input stim_t s, output obs_t o);
      @(negedge clk);
      KEY0          = s.key0;
      bus.tick      = s.tick;
      bus.mem_ready = s.ready;
      bus.alu_zero  = s.zero;
      #2;
      o.state        = bus.state;
      o.pc_we        = bus.pc_we;
      o.ir_we        = bus.ir_we;
      o.rf_we        = bus.rf_we;
      o.mem_we       = bus.mem_we;
      o.mem_re       = bus.mem_re;
      o.pc_src       = bus.pc_src;
      o.alu_op       = bus.alu_op;
      o.alu_src_imm  = bus.alu_src_imm;
      o.rf_dst_rt    = bus.rf_dst_rt;
      o.rf_wdata_mem = bus.rf_wdata_mem;
      o.trap         = bus.trap;
   endtask

   task automatic test_reset();
      obs_t o, e;
      int   cyc = 0;
      sb_push(0, 0, 1, 0, fe(0));
      sb_push(0, 0, 1, 0, fe(0));
      sb_push(1, 0, 1, 0, fe(0));
      load(6'b000000, 6'b100000);
      sb_push(1, 1, 1, 0, fe(1));
      sb_push(1, 1, 1, 0, ex(3'd1));
      sb_push(1, 0, 1, 0, ex(3'd2));
      // Reset lands while EXECUTE of the ADD is pending; tick=1 must not write anything.
      sb_push(0, 1, 0, 0, fe(0));
      sb_push(1, 0, 1, 0, fe(0));
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL reset cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      exp_ret = '0;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
      n_total++;
      if (bus.retired !== exp_ret) $display("FAIL reset retired: got %0d want %0d", bus.retired, exp_ret);
      else n_pass++;
`endif
   endtask

   task automatic test_alu_r();
      logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      obs_t o, e;
      int   cyc = 0;
      for (int i = 0; i < 5; i++) begin
         load(6'b000000, fn_tab[i]);
         sb_push(1, 1, 1, 0, fe(1));
         sb_push(1, 1, 1, 0, ex(3'd1));
         e = ex(3'd2); e.alu_op = 3'(i);
         sb_push(1, 1, 1, 0, e);
         e = ex(3'd4); e.rf_we = 1'b1;
         sb_push(1, 1, 1, 0, e);
         while (exp_q.size() > 0) begin
            drive_sample(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL alu_r[%0d] cyc%0d: got %h want %h", i, cyc, o, e);
            else n_pass++;
            cyc++;
         end
         exp_ret++;
      end
   endtask

   task automatic test_lw_wait();
      obs_t o, e;
      int   cyc = 0;
      load(6'b100011, 6'b000000);
      sb_push(1, 1, 0, 0, fe(0));
      sb_push(1, 1, 1, 0, fe(1));
      sb_push(1, 1, 1, 0, ex(3'd1));
      e = ex(3'd2); e.alu_src_imm = 1'b1;
      sb_push(1, 1, 1, 0, e);
      e = ex(3'd3); e.mem_re = 1'b1;
      repeat (3) sb_push(1, 1, 0, 0, e);
      sb_push(1, 0, 1, 0, e);
      sb_push(1, 1, 1, 0, e);
      e = ex(3'd4); e.rf_we = 1'b1; e.rf_dst_rt = 1'b1; e.rf_wdata_mem = 1'b1;
      sb_push(1, 1, 1, 0, e);
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL lw_wait cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      exp_ret++;
   endtask

   task automatic test_sw_j();
      obs_t o, e;
      int   cyc = 0;
      load(6'b101011, 6'b000000);
      sb_push(1, 1, 1, 0, fe(1));
      sb_push(1, 1, 1, 0, ex(3'd1));
      e = ex(3'd2); e.alu_src_imm = 1'b1;
      sb_push(1, 1, 1, 0, e);
      e = ex(3'd3); e.mem_we = 1'b1;
      sb_push(1, 1, 0, 0, e);
      sb_push(1, 1, 1, 0, e);
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL sw cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      load(6'b000010, 6'b000000);
      sb_push(1, 1, 1, 0, fe(1));
      sb_push(1, 1, 1, 0, ex(3'd1));
      e = ex(3'd2); e.pc_src = 2'd2; e.pc_we = 1'b1;
      sb_push(1, 1, 1, 0, e);
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL j cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      exp_ret += 2;
   endtask

   task automatic test_beq();
      obs_t o, e;
      for (int z = 1; z >= 0; z--) begin
         load(6'b000100, 6'b000000);
         sb_push(1, 1, 1, 1'(z), fe(1));
         sb_push(1, 1, 1, 1'(z), ex(3'd1));
         e = ex(3'd2); e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_we = 1'(z);
         sb_push(1, 1, 1, 1'(z), e);
         sb_push(1, 0, 1, 0, fe(0));
         while (exp_q.size() > 0) begin
            drive_sample(stim_q.pop_front(), o);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL beq z=%0d: got %h want %h", z, o, e);
            else n_pass++;
         end
         exp_ret++;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
         n_total++;
         if (bus.retired !== exp_ret) $display("FAIL beq retired z=%0d: got %0d want %0d", z, bus.retired, exp_ret);
         else n_pass++;
`endif
      end
   endtask

   task automatic test_illegal();
      obs_t o, e;
      int   cyc = 0;
      load(6'b111111, 6'b000000);
      sb_push(1, 1, 1, 0, fe(1));
      sb_push(1, 1, 1, 0, ex(3'd1));
      e = ex(3'd7); e.trap = 1'b1;
      repeat (20) sb_push(1, 1, 1, 1, e);
      sb_push(0, 0, 1, 0, fe(0));
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL illegal cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      exp_ret = '0;
   endtask

   task automatic test_tick_gating();
      obs_t o, e;
      int   cyc = 0;
      load(6'b100011, 6'b000000);
      repeat (10) sb_push(1, 0, 1, 1, fe(0));
      sb_push(1, 1, 1, 0, fe(1));
      repeat (10) sb_push(1, 0, 1, 1, ex(3'd1));
      sb_push(1, 1, 1, 0, ex(3'd1));
      e = ex(3'd2); e.alu_src_imm = 1'b1;
      repeat (10) sb_push(1, 0, 1, 1, e);
      sb_push(1, 1, 1, 0, e);
      e = ex(3'd3); e.mem_re = 1'b1;
      repeat (10) sb_push(1, 0, 1, 1, e);
      sb_push(1, 1, 1, 0, e);
      e = ex(3'd4); e.rf_dst_rt = 1'b1; e.rf_wdata_mem = 1'b1;
      repeat (10) sb_push(1, 0, 1, 1, e);
      e.rf_we = 1'b1;
      sb_push(1, 1, 1, 0, e);
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL tick_gating cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      exp_ret++;
   endtask

   task automatic test_nop_wrap();
      obs_t o, e;
      int   cyc = 0;
      load(6'b000000, 6'b000000);
      sb_push(0, 0, 1, 0, fe(0));
      for (int i = 0; i < 17; i++) begin
         sb_push(1, 1, 1, 0, fe(1));
         sb_push(1, 1, 1, 0, ex(3'd1));
         sb_push(1, 1, 1, 0, ex(3'd2));
      end
      sb_push(1, 0, 1, 0, fe(0));
      while (exp_q.size() > 0) begin
         drive_sample(stim_q.pop_front(), o);
         e = exp_q.pop_front();
         n_total++;
         if (o !== e) $display("FAIL nop_wrap cyc%0d: got %h want %h", cyc, o, e);
         else n_pass++;
         cyc++;
      end
      exp_ret = TB_RW'(17);
`ifdef MIPS_SEQ_RETIRE_CNT_EN
      n_total++;
      if (bus.retired !== exp_ret) $display("FAIL nop_wrap retired: got %0d want %0d", bus.retired, exp_ret);
      else n_pass++;
`endif
   endtask

   initial begin
      KEY0          = 1'b0;
      bus.tick      = 1'b0;
      bus.mem_ready = 1'b0;
      bus.alu_zero  = 1'b0;
      bus.opcode    = 6'b000000;
      bus.funct     = 6'b000000;
      test_reset();
      test_alu_r();
      test_lw_wait();
      test_sw_j();
      test_beq();
      test_tick_gating();
      test_illegal();
      test_nop_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
